// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing and test-pattern generator with a pixel-fetch port; sync/blank/colour emerge LAT+1 cycles after oRequest.
// No backpressure: the raster free-runs, and iEN low parks it at the origin while the delay line drains.
module vga_timing_gen #(
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int CW      = 11,
  parameter int DW      = 8,
  parameter int AW      = 19,
  parameter int LAT     = 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iEN,
  input  logic [1:0]    iMode,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  output logic          oRequest,
  output logic [CW-1:0] oCurrent_X,
  output logic [CW-1:0] oCurrent_Y,
  output logic [AW-1:0] oAddress,
  output logic [DW-1:0] oVGA_R,
  output logic [DW-1:0] oVGA_G,
  output logic [DW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC,
  output logic          oVGA_CLOCK,
  output logic          oFrame_Start,
  output logic          oLine_Start
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_ACT;
  localparam int BAR_W   = (H_ACT >= 8) ? H_ACT / 8 : 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic       ls;
    logic       grid;
    logic [2:0] bar;
    logic [1:0] mode;
  } stage_t;

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          h_last;
  logic          v_last;
  logic          in_act;
  logic [CW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;
  stage_t        cur;
  stage_t        idle;
  stage_t        last;
  stage_t        pipe [LAT];
  logic [DW-1:0] r_nxt;
  logic [DW-1:0] g_nxt;
  logic [DW-1:0] b_nxt;

  assign h_last = (h == CW'(H_TOTAL - 1));
  assign v_last = (v == CW'(V_TOTAL - 1));

  always_ff @(posedge iCLK) begin
    if (iRST || !iEN) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign in_act     = (h >= CW'(H_BLANK)) && (v >= CW'(V_BLANK));
  assign oRequest   = in_act && iEN && !iRST;
  assign oCurrent_X = oRequest ? h - CW'(H_BLANK) : '0;
  assign oCurrent_Y = oRequest ? v - CW'(V_BLANK) : '0;
  assign oAddress   = AW'(oCurrent_Y) * AW'(H_ACT) + AW'(oCurrent_X);

  // Bar index tracked incrementally so no divider by H_ACT/8 is needed.
  always_ff @(posedge iCLK) begin
    if (iRST || h == CW'(H_BLANK - 1)) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == CW'(BAR_W - 1)) begin
      bar_pos <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mode_q <= 2'b00;
    end else if (h == '0 && v == '0) begin
      mode_q <= iMode;
    end
  end

  always_comb begin
    cur      = '0;
    cur.hs   = (h >= CW'(H_FRONT) && h < CW'(H_FRONT + H_SYNC)) ? HS_POL : ~HS_POL;
    cur.vs   = (v >= CW'(V_FRONT) && v < CW'(V_FRONT + V_SYNC)) ? VS_POL : ~VS_POL;
    cur.act  = oRequest;
    cur.fs   = oRequest && oCurrent_X == '0 && oCurrent_Y == '0;
    cur.ls   = oRequest && oCurrent_X == '0;
    cur.grid = (oCurrent_X[4:0] == 5'd0) || (oCurrent_Y[4:0] == 5'd0) ||
               (oCurrent_X == CW'(H_ACT - 1)) || (oCurrent_Y == CW'(V_ACT - 1));
    cur.bar  = bar_idx;
    cur.mode = mode_q;
  end

  always_comb begin
    idle    = '0;
    idle.hs = ~HS_POL;
    idle.vs = ~VS_POL;
  end

  // Mode travels with each position so a frame boundary never splits modes mid-pipeline.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= idle;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[LAT-1];

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    if (last.act) begin
      case (last.mode)
        2'b00: begin
          r_nxt = iRed;
          g_nxt = iGreen;
          b_nxt = iBlue;
        end
        2'b01: begin
          r_nxt = last.bar[1] ? '0 : '1;
          g_nxt = last.bar[2] ? '0 : '1;
          b_nxt = last.bar[0] ? '0 : '1;
        end
        2'b10: begin
          if (last.grid) begin
            r_nxt = '1;
            g_nxt = '1;
            b_nxt = '1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oVGA_HS      <= ~HS_POL;
      oVGA_VS      <= ~VS_POL;
      oVGA_BLANK   <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oFrame_Start <= 1'b0;
      oLine_Start  <= 1'b0;
    end else begin
      oVGA_HS      <= last.hs;
      oVGA_VS      <= last.vs;
      oVGA_BLANK   <= last.act;
      oVGA_R       <= r_nxt;
      oVGA_G       <= g_nxt;
      oVGA_B       <= b_nxt;
      oFrame_Start <= last.fs;
      oLine_Start  <= last.ls;
    end
  end

  assign oVGA_SYNC  = 1'b1;
  assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Randomized bench for vga_timing_gen: a cycle-indexed raster model predicts every output each cycle.
module tb_vga_timing_gen;

  localparam int HF = 2, HSW = 3, HBP = 1, HA = 8;
  localparam int VF = 1, VSW = 1, VBP = 1, VA = 4;
  localparam int LAT = 2;
  localparam int HBL = HF + HSW + HBP, HT = HBL + HA;
  localparam int VBL = VF + VSW + VBP, VT = VBL + VA;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [7:0]  red, green, blue;
  logic        req;
  logic [10:0] cur_x, cur_y;
  logic [18:0] addr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank, vga_sync, vga_clock, frame_start, line_start;
  logic [7:0]  mp0, mp1;

  vga_timing_gen #(
    .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP), .H_ACT(HA),
    .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .V_ACT(VA),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .DW(8), .AW(19), .LAT(LAT)
  ) dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .iMode(mode),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oRequest(req), .oCurrent_X(cur_x), .oCurrent_Y(cur_y), .oAddress(addr),
    .oVGA_R(vga_r), .oVGA_G(vga_g), .oVGA_B(vga_b),
    .oVGA_HS(vga_hs), .oVGA_VS(vga_vs), .oVGA_BLANK(vga_blank),
    .oVGA_SYNC(vga_sync), .oVGA_CLOCK(vga_clock),
    .oFrame_Start(frame_start), .oLine_Start(line_start)
  );

  always #5 clk = ~clk;

  // Pixel memory: returns (a function of) the requested address LAT=2 cycles later.
  always @(posedge clk) begin
    mp0 <= addr[7:0];
    mp1 <= mp0;
  end
  assign red   = mp1;
  assign green = mp1 ^ 8'h5A;
  assign blue  = ~mp1;

  typedef struct { int hs; int vs; int act; int x; int y; int addr; int mode; } rec_t;
  typedef struct { int hs; int vs; int blank; int r; int g; int b; int fs; int ls; } out_t;

  rec_t q[$];
  rec_t idle_r;
  out_t ex;
  int   n_model, hm, vm, mode_l;
  int   errors, checks;
  int   agg_on, c_hs, c_vs, c_req, c_blank, c_fs, c_ls, c_nz, oob;
  bit   seen_fs, seen_req;
  bit [2:0] bar_tbl [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic rec_t cur_rec();
    rec_t r;
    r.act  = (hm >= HBL && vm >= VBL && en && !rst) ? 1 : 0;
    r.hs   = (hm >= HF && hm < HF + HSW) ? 0 : 1;
    r.vs   = (vm >= VF && vm < VF + VSW) ? 0 : 1;
    r.x    = r.act ? hm - HBL : 0;
    r.y    = r.act ? vm - VBL : 0;
    r.addr = r.y * HA + r.x;
    r.mode = mode_l;
    return r;
  endfunction

  function automatic out_t out_of(rec_t r);
    out_t o;
    bit [2:0] c;
    int a;
    o.hs = r.hs; o.vs = r.vs; o.blank = r.act;
    o.fs = (r.act != 0 && r.x == 0 && r.y == 0) ? 1 : 0;
    o.ls = (r.act != 0 && r.x == 0) ? 1 : 0;
    o.r = 0; o.g = 0; o.b = 0;
    if (r.act != 0) begin
      case (r.mode)
        0: begin
          a = r.addr % 256;
          o.r = a; o.g = a ^ 'h5A; o.b = 255 - a;
        end
        1: begin
          c = bar_tbl[r.x / (HA / 8)];
          o.r = c[2] ? 255 : 0; o.g = c[1] ? 255 : 0; o.b = c[0] ? 255 : 0;
        end
        2: begin
          if (r.x % 32 == 0 || r.y % 32 == 0 || r.x == HA - 1 || r.y == VA - 1) begin
            o.r = 255; o.g = 255; o.b = 255;
          end
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic model_edge(rec_t c);
    if (rst) begin
      ex = out_of(idle_r);
      q.delete();
      repeat (LAT) q.push_back(idle_r);
      mode_l  = 0;
      n_model = 0;
    end else begin
      ex = out_of(q.pop_front());
      q.push_back(c);
      if (hm == 0 && vm == 0) mode_l = mode;
      n_model = en ? n_model + 1 : 0;
    end
    hm = n_model % HT;
    vm = (n_model / HT) % VT;
  endtask

  task automatic tick();
    rec_t c;
    #1;
    c = cur_rec();
    check("req", req, c.act);
    check("cur_x", cur_x, c.x);
    check("cur_y", cur_y, c.y);
    check("addr", addr, c.addr);
    check("hs", vga_hs, ex.hs);
    check("vs", vga_vs, ex.vs);
    check("blank", vga_blank, ex.blank);
    check("red", vga_r, ex.r);
    check("green", vga_g, ex.g);
    check("blue", vga_b, ex.b);
    check("frame_start", frame_start, ex.fs);
    check("line_start", line_start, ex.ls);
    seen_fs  = frame_start;
    seen_req = req;
    if (addr >= HA * VA) oob++;
    if (agg_on != 0) begin
      if (!vga_hs) c_hs++;
      if (!vga_vs) c_vs++;
      if (req) c_req++;
      if (vga_blank) c_blank++;
      if (frame_start) c_fs++;
      if (line_start) c_ls++;
      if (vga_blank && (vga_r | vga_g | vga_b) != 0) c_nz++;
    end
    model_edge(c);
    @(negedge clk);
  endtask

  task automatic agg_clear();
    c_hs = 0; c_vs = 0; c_req = 0; c_blank = 0; c_fs = 0; c_ls = 0; c_nz = 0;
  endtask

  task automatic wait_pos(string tag, int th, int tv);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (hm == th && vm == tv) begin
        ok = 1;
        break;
      end
      tick();
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int lat, en_hold;
    errors = 0; checks = 0; agg_on = 0; oob = 0;
    agg_clear();
    rst = 1'b1; en = 1'b0; mode = 2'b00;
    idle_r.hs = 1; idle_r.vs = 1; idle_r.act = 0;
    idle_r.x = 0; idle_r.y = 0; idle_r.addr = 0; idle_r.mode = 0;
    repeat (LAT) q.push_back(idle_r);
    n_model = 0; hm = 0; vm = 0; mode_l = 0;
    ex = out_of(idle_r);
    @(negedge clk);
    repeat (2) tick();

    #1;
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank", vga_blank, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ls", line_start, 0);
    check("rst_req", req, 0);
    check("sync_const", vga_sync, 1);
    check("vga_clock", vga_clock, !clk);

    // Steady pass-through: per-frame sync and request totals.
    rst = 1'b0; en = 1'b1;
    repeat (101) tick();
    agg_clear(); agg_on = 1;
    repeat (VT * HT) tick();
    agg_on = 0;
    check("hs_low_per_frame", c_hs, HSW * VT);
    check("vs_low_per_frame", c_vs, VSW * HT);
    check("req_per_frame", c_req, HA * VA);
    check("blank_hi_per_frame", c_blank, HA * VA);
    check("fs_per_frame", c_fs, 1);
    check("ls_per_frame", c_ls, VA);

    // Mode change mid-frame only takes effect at the next frame.
    wait_pos("wait_mid_frame", HBL + 2, VBL + 1);
    mode = 2'b11;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (seen_fs) begin
        lat = k;
        break;
      end
    end
    check("wait_black_fs", lat >= 0, 1);
    agg_clear(); agg_on = 1;
    repeat (VT * HT) tick();
    agg_on = 0;
    check("black_frame_nz", c_nz, 0);
    check("black_frame_blank", c_blank, HA * VA);

    // One-cycle reset at V=5, then latency to the next frame start.
    mode = 2'b00;
    wait_pos("wait_v5", 3, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (seen_fs) begin
        lat = k;
        break;
      end
    end
    check("rst_to_fs_latency", lat, VBL * HT + HBL + LAT + 1);

    // Enable dropped for 50 cycles mid-line.
    wait_pos("wait_mid_line", HBL + 3, VBL + 2);
    en = 1'b0;
    agg_clear(); agg_on = 1;
    repeat (50) tick();
    agg_on = 0;
    check("en_off_req", c_req, 0);
    en = 1'b1;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (seen_req) begin
        lat = k;
        break;
      end
    end
    check("reenable_first_req", lat, VBL * HT + HBL);

    mode = 2'b01;
    repeat (2 * VT * HT) tick();
    mode = 2'b10;
    repeat (2 * VT * HT) tick();

    en_hold = 0;
    repeat (800) begin
      rst = ($urandom_range(0, 299) == 0);
      if (en_hold > 0) begin
        en = 1'b0;
        en_hold--;
      end else begin
        en = 1'b1;
        if ($urandom_range(0, 59) == 0) en_hold = $urandom_range(1, 20);
      end
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; en = 1'b1;
    repeat (VT * HT) tick();

    check("addr_range", oob, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
